// File: rtl/seq_mult_ctrl.sv
// Sequential unsigned shift-add multiplier controller.
// Owns the multiplicand, product and iteration registers and time-shares one
// external WIDTH-bit adder: each RUN cycle adds the multiplicand (gated by the
// current product LSB) into the upper product half and shifts right by one.
module seq_mult_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  output logic                 add_cin,
  input  logic [WIDTH-1:0]     add_sum,
  input  logic                 add_cout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Next-state, datapath and registered-output computation for the FSM.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d = op_a;
          prod_d  = {{WIDTH{1'b0}}, op_b};
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Carry-out becomes the new MSB; start is ignored while running.
        prod_d = {add_cout, add_sum, prod_q[WIDTH-1:1]};
        cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (start) begin
          mcand_d = op_a;
          prod_d  = {{WIDTH{1'b0}}, op_b};
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mcand_q <= {WIDTH{1'b0}};
      prod_q  <= {(2*WIDTH){1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Adder operands come straight from registers in every state.
  always_comb begin
    add_a   = prod_q[2*WIDTH-1:WIDTH];
    add_cin = 1'b0;
    if (prod_q[0]) begin
      add_b = mcand_q;
    end else begin
      add_b = {WIDTH{1'b0}};
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed testbench for seq_mult_ctrl with a behavioural 32-bit adder.
module tb_seq_mult_ctrl;

  localparam int WIDTH = 32;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   add_a;
  logic [WIDTH-1:0]   add_b;
  logic               add_cin;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;

  int checks;
  int errors;

  seq_mult_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  // External full adder
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one accepting edge; returns at the negedge after that edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for done, counting negedges already elapsed in first_n; bounded.
  task automatic wait_done(input int first_n, output int cycles);
    cycles = -1;
    if (done) begin
      cycles = first_n;
    end else begin
      for (int n = first_n + 1; n <= 60; n++) begin
        @(negedge clk);
        if (done) begin
          cycles = n;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    op_a  = 32'd0;
    op_b  = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags busy=%b done=%b required 0 0", busy, done);
    end
    checks++;
    if (product !== 64'd0) begin
      errors++;
      $display("FAIL reset_product got %h required 0", product);
    end
    checks++;
    if (add_b !== 32'd0 || add_a !== 32'd0 || add_cin !== 1'b0) begin
      errors++;
      $display("FAIL reset_adder add_a=%h add_b=%h cin=%b required 0", add_a, add_b, add_cin);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_multiply();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [63:0] vp [4];
    int cyc;
    va[0] = 32'd3;          vb[0] = 32'd5;          vp[0] = 64'h0000_0000_0000_000F;
    va[1] = 32'hFFFF_FFFF;  vb[1] = 32'hFFFF_FFFF;  vp[1] = 64'hFFFF_FFFE_0000_0001;
    va[2] = 32'd0;          vb[2] = 32'h0000_1234;  vp[2] = 64'd0;
    va[3] = 32'h0000_1234;  vb[3] = 32'd0;          vp[3] = 64'd0;
    for (int i = 0; i < 4; i++) begin
      start_op(va[i], vb[i]);
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL mul_busy[%0d] got %b required 1", i, busy);
      end
      wait_done(1, cyc);
      checks++;
      if (cyc !== 33) begin
        errors++;
        $display("FAIL mul_latency[%0d] got %0d required 33", i, cyc);
      end
      checks++;
      if (product !== vp[i] || busy !== 1'b0) begin
        errors++;
        $display("FAIL mul_product[%0d] got %h busy=%b required %h", i, product, busy, vp[i]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || product !== vp[i]) begin
        errors++;
        $display("FAIL mul_idle_hold[%0d] done=%b product=%h required 0 %h", i, done, product, vp[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int dones;
    int first;
    start_op(32'd7, 32'd9);
    dones = 0;
    first = -1;
    for (int n = 2; n <= 50; n++) begin
      if (n == 10) begin
        op_a  = 32'd2;
        op_b  = 32'd2;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        dones++;
        if (first < 0) begin
          first = n;
          checks++;
          if (product !== 64'd63) begin
            errors++;
            $display("FAIL ignore_product got %0d required 63", product);
          end
        end
      end
    end
    checks++;
    if (dones !== 1 || first !== 33) begin
      errors++;
      $display("FAIL ignore_done count=%0d at=%0d required 1 at 33", dones, first);
    end
  endtask

  task automatic test_reset_abort();
    int dones;
    int cyc;
    start_op(32'd11, 32'd13);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
      errors++;
      $display("FAIL abort_state busy=%b done=%b product=%h required 0 0 0", busy, done, product);
    end
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL abort_no_done got %0d dones required 0", dones);
    end
    start_op(32'd6, 32'd7);
    wait_done(1, cyc);
    checks++;
    if (cyc !== 33 || product !== 64'd42) begin
      errors++;
      $display("FAIL abort_after got %0d at %0d required 42 at 33", product, cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc;
    int cyc2;
    start_op(32'd5, 32'd5);
    wait_done(1, cyc);
    checks++;
    if (cyc !== 33 || product !== 64'd25) begin
      errors++;
      $display("FAIL b2b_first got %0d at %0d required 25 at 33", product, cyc);
    end
    start_op(32'd10, 32'd10);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart busy=%b done=%b required 1 0", busy, done);
    end
    wait_done(1, cyc);
    checks++;
    if (cyc !== 33 || product !== 64'd100) begin
      errors++;
      $display("FAIL b2b_second got %0d at %0d required 100 at 33", product, cyc);
    end
    @(negedge clk);
    // Start held high: one operation every WIDTH+1 cycles.
    op_a  = 32'd4;
    op_b  = 32'd6;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_done(1, cyc);
    op_a = 32'd8;
    op_b = 32'd9;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL hold_restart busy got %b required 1", busy);
    end
    wait_done(1, cyc2);
    start = 1'b0;
    checks++;
    if (cyc !== 33 || cyc2 !== 33 || product !== 64'd72) begin
      errors++;
      $display("FAIL hold_period got %0d,%0d product %0d required 33,33 72", cyc, cyc2, product);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL hold_release busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_multiply();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
